// File: rtl/prog_launch_pkg.sv
// Shared types and constants for the program-launch controller.
//   state_t     : controller state encoding
//   DEF_BASE*   : default absolute start addresses of the three test programs
//   PROG_IDX_W  : width of the program-number output
package prog_launch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int unsigned DEF_BASE1  = 32'd0;
  localparam int unsigned DEF_BASE2  = 32'd100;
  localparam int unsigned DEF_BASE3  = 32'd200;
  localparam int unsigned PROG_IDX_W = 32'd2;

endpackage : prog_launch_pkg

// File: rtl/start_edge_det.sv
// Registers the bench Start level and flags its rising and falling edges.
// The register keeps tracking In in every controller state, so an edge that
// the controller chooses to ignore is simply lost rather than remembered.
// Ports:
//   Clk   in  clock, posedge
//   Reset in  synchronous active-high reset (clears the sample to 0)
//   In    in  level to watch
//   Rise  out In is high now and was low at the previous edge
//   Fall  out In is low now and was high at the previous edge
module start_edge_det (
  input  logic Clk,
  input  logic Reset,
  input  logic In,
  output logic Rise,
  output logic Fall
);

  logic in_r;

  // Previous-cycle sample of In; cleared by reset so a level held high
  // across reset release is seen as a fresh rise.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      in_r <= 1'b0;
    end else begin
      in_r <= In;
    end
  end

  // Edge decode from the current level and the previous sample.
  always_comb begin
    Rise = ~in_r & In;
    Fall = in_r & ~In;
  end

endmodule : start_edge_det

// File: rtl/prog_launch_ctrl.sv
// Program-launch controller. Turns Start pulses into per-program PC loads,
// holds the PC between programs and stops fetch on the decoder halt flag.
// Ports:
//   Clk        in   clock, posedge
//   Reset      in   synchronous active-high reset, overrides everything
//   Start      in   bench request level; launch happens on its falling edge
//   Halt       in   currently fetched instruction is the halt opcode
//   PcLoad     out  one-cycle load strobe to the PC register
//   PcLoadAddr out  absolute load address (0 when not loading)
//   PcHold     out  PC keeps its value (also suppresses branches)
//   Done       out  current program has finished
//   ProgIdx    out  current program number, 0 before the first launch
//   CycleCnt   out  RUN cycles of the current program, saturating
module prog_launch_ctrl
  import prog_launch_pkg::*;
#(
  parameter int unsigned A         = 10,
  parameter int unsigned NUM_PROGS = 3,
  parameter int unsigned BASE1     = DEF_BASE1,
  parameter int unsigned BASE2     = DEF_BASE2,
  parameter int unsigned BASE3     = DEF_BASE3,
  parameter int unsigned CW        = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic                  Halt,
  output logic                  PcLoad,
  output logic [A-1:0]          PcLoadAddr,
  output logic                  PcHold,
  output logic                  Done,
  output logic [PROG_IDX_W-1:0] ProgIdx,
  output logic [CW-1:0]         CycleCnt
);

  localparam logic [PROG_IDX_W-1:0] LAST_IDX = PROG_IDX_W'(NUM_PROGS);
  localparam logic [PROG_IDX_W-1:0] IDX_ONE  = PROG_IDX_W'(1);
  localparam logic [CW-1:0]         CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);

  state_t                  state_r, state_s;
  logic [PROG_IDX_W-1:0]   prog_idx_r, prog_idx_s;
  logic [CW-1:0]           cycle_cnt_r, cycle_cnt_s;
  logic [A-1:0]            base_addr_s;
  logic                    rise_s, fall_s;

  start_edge_det u_start_edge_det (
    .Clk   (Clk),
    .Reset (Reset),
    .In    (Start),
    .Rise  (rise_s),
    .Fall  (fall_s)
  );

  // State, program number and cycle counter registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      prog_idx_r  <= '0;
      cycle_cnt_r <= '0;
    end else begin
      state_r     <= state_s;
      prog_idx_r  <= prog_idx_s;
      cycle_cnt_r <= cycle_cnt_s;
    end
  end

  // Start address of the program currently selected.
  always_comb begin
    case (prog_idx_r)
      2'd1:    base_addr_s = A'(BASE1);
      2'd2:    base_addr_s = A'(BASE2);
      2'd3:    base_addr_s = A'(BASE3);
      default: base_addr_s = '0;
    endcase
  end

  // Next-state logic, program advance and saturating RUN-cycle count.
  always_comb begin
    state_s     = state_r;
    prog_idx_s  = prog_idx_r;
    cycle_cnt_s = cycle_cnt_r;
    case (state_r)
      IDLE, DONE: begin
        // Once the last program has run, further requests leave Done up.
        if (rise_s && (prog_idx_r < LAST_IDX)) begin
          state_s     = ARMED;
          prog_idx_s  = prog_idx_r + IDX_ONE;
          cycle_cnt_s = '0;
        end else begin
          state_s = state_r;
        end
      end
      ARMED: begin
        if (fall_s) begin
          state_s = LOAD;
        end else begin
          state_s = ARMED;
        end
      end
      LOAD: begin
        state_s = RUN;
      end
      RUN: begin
        // The halt cycle itself is counted.
        if (cycle_cnt_r != CNT_MAX) begin
          cycle_cnt_s = cycle_cnt_r + CNT_ONE;
        end else begin
          cycle_cnt_s = cycle_cnt_r;
        end
        if (Halt) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Moore outputs, except PcHold which also reacts to Halt in the same
  // cycle so the PC parks on the halt instruction.
  always_comb begin
    PcLoad     = 1'b0;
    PcLoadAddr = '0;
    PcHold     = 1'b1;
    Done       = 1'b0;
    if (state_r == LOAD) begin
      PcLoad     = 1'b1;
      PcLoadAddr = base_addr_s;
    end else begin
      PcLoad     = 1'b0;
      PcLoadAddr = '0;
    end
    if (state_r == RUN) begin
      PcHold = Halt;
    end else begin
      PcHold = 1'b1;
    end
    Done     = (state_r == DONE);
    ProgIdx  = prog_idx_r;
    CycleCnt = cycle_cnt_r;
  end

endmodule : prog_launch_ctrl

// File: tb/tb_prog_launch_ctrl.sv
// Directed bench for prog_launch_ctrl. Inputs are driven 1 time unit after
// the rising edge and outputs are compared at that point, away from the
// edge. The counter width is reduced to 4 bits so saturation is reachable.
module tb_prog_launch_ctrl;

  localparam int TB_CW = 4;

  logic             Clk;
  logic             Reset;
  logic             Start;
  logic             Halt;
  logic             PcLoad;
  logic [9:0]       PcLoadAddr;
  logic             PcHold;
  logic             Done;
  logic [1:0]       ProgIdx;
  logic [TB_CW-1:0] CycleCnt;

  int errors = 0;
  int checks = 0;
  int load_pulses = 0;

  prog_launch_ctrl #(
    .A         (10),
    .NUM_PROGS (3),
    .BASE1     (0),
    .BASE2     (100),
    .BASE3     (200),
    .CW        (TB_CW)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Halt       (Halt),
    .PcLoad     (PcLoad),
    .PcLoadAddr (PcLoadAddr),
    .PcHold     (PcHold),
    .Done       (Done),
    .ProgIdx    (ProgIdx),
    .CycleCnt   (CycleCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count PcLoad pulses, sampled mid-cycle.
  always @(negedge Clk) begin
    if (PcLoad === 1'b1) load_pulses = load_pulses + 1;
  end

  // Safety net: the directed sequence is far shorter than this.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start high for three cycles then low; ends one edge into RUN.
  task automatic launch(input int base, input int idx, input int loads, input bit halt_in_load);
    Start = 1'b1;
    tick();
    check("armed_idx", ProgIdx, idx);
    check("armed_done", Done, 0);
    check("armed_noload", PcLoad, 0);
    tick();
    tick();
    check("armed_hold", PcHold, 1);
    Start = 1'b0;
    tick();
    check("load_pulse", PcLoad, 1);
    check("load_addr", PcLoadAddr, base);
    check("load_hold", PcHold, 1);
    if (halt_in_load) Halt = 1'b1;
    tick();
    Halt = 1'b0;
    #1;
    check("run_noload", PcLoad, 0);
    check("run_addr0", PcLoadAddr, 0);
    check("run_hold", PcHold, 0);
    check("run_done", Done, 0);
    check("run_cnt0", CycleCnt, 0);
    check("load_count", load_pulses, loads);
  endtask

  // Run n cycles in RUN with Halt on the n-th; optional Start toggle mid-run.
  task automatic run_prog(input int n, input int final_cnt, input bit toggle);
    int exp_cnt;
    for (int k = 1; k <= n; k++) begin
      if (toggle && k == 2) Start = 1'b1;
      if (toggle && k == 3) Start = 1'b0;
      if (k == n) begin
        Halt = 1'b1;
        #1;
        check("halt_hold", PcHold, 1);
      end else begin
        check("run_hold_k", PcHold, 0);
      end
      tick();
      exp_cnt = (k > 15) ? 15 : k;
      check("run_cnt", CycleCnt, exp_cnt);
    end
    Halt = 1'b0;
    #1;
    check("done_flag", Done, 1);
    check("done_cnt", CycleCnt, final_cnt);
    check("done_hold", PcHold, 1);
    check("done_noload", PcLoad, 0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    Halt  = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    check("rst_hold", PcHold, 1);
    check("rst_done", Done, 0);
    check("rst_idx", ProgIdx, 0);
    check("rst_load", PcLoad, 0);
    check("rst_addr", PcLoadAddr, 0);
    check("rst_cnt", CycleCnt, 0);

    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle_hold", PcHold, 1);
      check("idle_done", Done, 0);
      check("idle_idx", ProgIdx, 0);
    end
    check("idle_noload", load_pulses, 0);

    // Program 1, halt on the 10th RUN cycle.
    launch(0, 1, 1, 1'b0);
    run_prog(10, 10, 1'b0);

    // Program 2 with Halt during LOAD and a Start toggle in RUN, then reset.
    launch(100, 2, 2, 1'b1);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    tick();
    tick();
    check("p2_run_done", Done, 0);
    check("p2_run_idx", ProgIdx, 2);
    check("p2_run_cnt", CycleCnt, 4);
    check("p2_run_hold", PcHold, 0);
    check("p2_run_loads", load_pulses, 2);

    // Reset in RUN with Start held high across its release.
    Reset = 1'b1;
    Start = 1'b1;
    tick();
    check("mrst_idx", ProgIdx, 0);
    check("mrst_cnt", CycleCnt, 0);
    check("mrst_hold", PcHold, 1);
    check("mrst_done", Done, 0);
    check("mrst_load", PcLoad, 0);
    Reset = 1'b0;
    tick();
    check("post_rst_rise_idx", ProgIdx, 1);
    tick();
    Start = 1'b0;
    tick();
    check("post_rst_load", PcLoad, 1);
    check("post_rst_addr", PcLoadAddr, 0);
    tick();
    check("post_rst_run_hold", PcHold, 0);
    check("post_rst_loads", load_pulses, 3);
    run_prog(3, 3, 1'b0);

    // Program 2 again, Start toggled during RUN; nothing is remembered.
    launch(100, 2, 4, 1'b0);
    run_prog(5, 5, 1'b1);
    check("toggle_idx", ProgIdx, 2);
    tick();
    tick();
    check("toggle_stay_done", Done, 1);
    check("toggle_stay_idx", ProgIdx, 2);
    check("toggle_loads", load_pulses, 4);

    // Program 3, long enough to saturate the 4-bit counter.
    launch(200, 3, 5, 1'b0);
    run_prog(20, 15, 1'b0);

    // Fourth request after the last program is ignored.
    Start = 1'b1;
    tick();
    check("p4_done", Done, 1);
    check("p4_idx", ProgIdx, 3);
    tick();
    tick();
    Start = 1'b0;
    tick();
    check("p4_noload", PcLoad, 0);
    tick();
    check("p4_done_hold", Done, 1);
    check("p4_cnt", CycleCnt, 15);
    check("p4_loads", load_pulses, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_prog_launch_ctrl
